// File: rtl/ddr3_reset_sequencer.sv
// -----------------------------------------------------------------------------
// ddr3_reset_sequencer
//
// Power-up / recovery reset sequencer for a DDR3 memory-controller subsystem.
// It waits for the PLL to lock and holds the controller in reset for a fixed
// time. It then waits for calibration, with a timeout, and lets the result
// settle. Only after that does it release user logic. Losing lock or losing
// calibration walks the sequence back to the right point. A calibration
// timeout is terminal until reset_n is asserted.
//
// Parameters
//   HOLD_CYCLES          controller reset hold after lock      (1..65535)
//   CALIB_TIMEOUT_CYCLES max cycles spent waiting for calib    (1..2^24-1)
//   SETTLE_CYCLES        delay from calib done to user release (1..65535)
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   async assert / sync deassert, active-low
//   pll_locked     in   PLL lock, asynchronous to clk (synchronized here)
//   calib_complete in   controller calibration done, synchronous to clk
//   mig_sys_rst_n  out  active-low reset to the memory controller
//   user_reset_n   out  active-low reset to user logic
//   timeout_error  out  calibration timeout, held until reset_n asserts
//   state_o        out  current state encoding (debug)
//
// State encodings: IDLE=0 WAIT_LOCK=1 HOLD=2 WAIT_CALIB=3 SETTLE=4 RUN=5
// ERROR=6. Encoding 7 is never entered and recovers to IDLE.
// -----------------------------------------------------------------------------
module ddr3_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES          = 16,
  parameter int unsigned CALIB_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned SETTLE_CYCLES        = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       calib_complete,
  output logic       mig_sys_rst_n,
  output logic       user_reset_n,
  output logic       timeout_error,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_WAIT_CALIB = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_RUN        = 3'd5,
    ST_ERROR      = 3'd6
  } state_e;

  // One counter serves every timed state, so it is sized for the largest of
  // the three durations.
  localparam int unsigned MAX_HS     = (HOLD_CYCLES > SETTLE_CYCLES) ?
                                       HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYCLES = (CALIB_TIMEOUT_CYCLES > MAX_HS) ?
                                       CALIB_TIMEOUT_CYCLES : MAX_HS;
  localparam int          CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  // The counter holds the number of cycles already spent in the current
  // state. A state of length N therefore exits when the counter reads N-1.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  // ---------------------------------------------------------------------------
  // pll_locked synchronizer (two flops, placed adjacently by the tools)
  // ---------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       locked;

  always_comb begin
    sync_d = {sync_q[0], pll_locked};
  end

  // NOTE: sequential state uses non-blocking (<=) assignments. Then every
  // flop samples the values from before the edge, whatever order the blocks
  // run in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign locked = sync_q[1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. In every active state, lock loss is checked first so
  // that it overrides a simultaneous calib_complete edge or timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each variable written here gets a default first. A path that
    // leaves one unassigned would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!locked)                 state_d = ST_WAIT_LOCK;
        else if (cnt_q == HOLD_LAST) state_d = ST_WAIT_CALIB;
      end
      ST_WAIT_CALIB: begin
        if (!locked)                    state_d = ST_WAIT_LOCK;
        else if (calib_complete)        state_d = ST_SETTLE;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_ERROR;
      end
      ST_SETTLE: begin
        if (!locked)                   state_d = ST_WAIT_LOCK;
        else if (!calib_complete)      state_d = ST_WAIT_CALIB;
        else if (cnt_q == SETTLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked)              state_d = ST_WAIT_LOCK;
        else if (!calib_complete) state_d = ST_WAIT_CALIB;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clearing on every state change covers each "counter cleared on entry"
  // case at once. The counter saturates so that a long stay in RUN or
  // WAIT_LOCK can never wrap it back into a terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. They are decoded from the next state and registered, so
  // each output changes on the same edge that enters its state and never
  // glitches.
  // ---------------------------------------------------------------------------
  logic mig_rst_n_d, mig_rst_n_q;
  logic user_rst_n_d, user_rst_n_q;
  logic timeout_d, timeout_q;

  always_comb begin
    mig_rst_n_d  = 1'b0;
    user_rst_n_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_d)
      ST_WAIT_CALIB,
      ST_SETTLE:     mig_rst_n_d = 1'b1;
      ST_RUN: begin
        mig_rst_n_d  = 1'b1;
        user_rst_n_d = 1'b1;
      end
      ST_ERROR:      timeout_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mig_rst_n_q  <= 1'b0;
      user_rst_n_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      mig_rst_n_q  <= mig_rst_n_d;
      user_rst_n_q <= user_rst_n_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mig_sys_rst_n = mig_rst_n_q;
  assign user_reset_n  = user_rst_n_q;
  assign timeout_error = timeout_q;
  assign state_o       = state_q;

  // ---------------------------------------------------------------------------
  // Embedded checks (ignored by synthesis)
  // ---------------------------------------------------------------------------
  a_no_illegal_state: assert property (@(posedge clk) disable iff (!reset_n)
    state_o != 3'd7);

  a_user_implies_mig: assert property (@(posedge clk) disable iff (!reset_n)
    user_reset_n |-> mig_sys_rst_n);

  a_error_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    timeout_error |-> (!mig_sys_rst_n && !user_reset_n));

endmodule

// File: tb/tb_ddr3_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ddr3_reset_sequencer
//
// Directed scenarios plus a randomized run for ddr3_reset_sequencer, using
// HOLD=4, TIMEOUT=16 and SETTLE=3. A behavioural model tracks the sequencer
// as "which phase we are in and how long we have been there". It is built
// from the phase rules and plain arithmetic. Each scenario also checks the
// latencies that matter against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_ddr3_reset_sequencer;

  localparam int HOLD = 4;
  localparam int TMO  = 16;
  localparam int SET  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       calib_complete = 1'b0;
  logic       mig_sys_rst_n;
  logic       user_reset_n;
  logic       timeout_error;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  ddr3_reset_sequencer #(
    .HOLD_CYCLES          (HOLD),
    .CALIB_TIMEOUT_CYCLES (TMO),
    .SETTLE_CYCLES        (SET)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .calib_complete (calib_complete),
    .mig_sys_rst_n  (mig_sys_rst_n),
    .user_reset_n   (user_reset_n),
    .timeout_error  (timeout_error),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  wire [5:0] dut_vec = {state_o, mig_sys_rst_n, user_reset_n, timeout_error};

  // ---------------------------------------------------------------------------
  // Reference model.
  // Phases: 0 idle, 1 wait lock, 2 hold, 3 wait calib, 4 settle, 5 run,
  // 6 error. lock_pipe is the two-cycle-delayed view of pll_locked.
  // ---------------------------------------------------------------------------
  int m_phase;
  int m_time_in_phase;
  bit lock_pipe[2];

  function automatic void model_reset();
    m_phase         = 0;
    m_time_in_phase = 0;
    lock_pipe[0]    = 1'b0;
    lock_pipe[1]    = 1'b0;
  endfunction

  function automatic void model_clock();
    bit seen_lock;
    int next_phase;
    seen_lock  = lock_pipe[1];
    next_phase = m_phase;
    if (!reset_n) begin
      model_reset();
    end else begin
      lock_pipe[1] = lock_pipe[0];
      lock_pipe[0] = pll_locked;
      if (m_phase == 0) begin
        next_phase = 1;
      end else if (m_phase == 1) begin
        if (seen_lock) next_phase = 2;
      end else if (m_phase >= 2 && m_phase <= 5 && !seen_lock) begin
        next_phase = 1;
      end else if (m_phase == 2) begin
        if (m_time_in_phase + 1 == HOLD) next_phase = 3;
      end else if (m_phase == 3) begin
        if (calib_complete)                  next_phase = 4;
        else if (m_time_in_phase + 1 == TMO) next_phase = 6;
      end else if (m_phase == 4) begin
        if (!calib_complete)                 next_phase = 3;
        else if (m_time_in_phase + 1 == SET) next_phase = 5;
      end else if (m_phase == 5) begin
        if (!calib_complete) next_phase = 3;
      end
      m_time_in_phase = (next_phase == m_phase) ? m_time_in_phase + 1 : 0;
      m_phase = next_phase;
    end
  endfunction

  function automatic logic [5:0] model_vec();
    logic [2:0] p;
    p = 3'(m_phase);
    return {p, (m_phase >= 3 && m_phase <= 5), (m_phase == 5), (m_phase == 6)};
  endfunction

  // One clock: advance the model at the edge, then leave 1 ns so that the
  // outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic start_from_reset(input logic pll, input logic calib);
    reset_n        = 1'b0;
    pll_locked     = pll;
    calib_complete = calib;
    model_reset();
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    start_from_reset(1'b0, 1'b0);
    checks++;
    if (dut_vec !== 6'b000_000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", dut_vec, 6'b000_000);
    end
    step();
    checks++;
    if (dut_vec !== {3'd1, 3'b000}) begin
      errors++;
      $display("FAIL idle_one_cycle: got %b expected %b", dut_vec, {3'd1, 3'b000});
    end
    repeat (4) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL wait_lock_hold: got %b expected %b", dut_vec, model_vec());
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_nominal();
    int n;
    start_from_reset(1'b1, 1'b0);
    n = 0;
    while (state_o !== 3'd2 && n < 20) begin
      step();
      n++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL nominal_to_hold: got %b expected %b", dut_vec, model_vec());
      end
    end
    // One idle cycle plus two synchronizer cycles.
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL nominal_hold_entry: got %0d cycles expected 3", n);
    end
    n = 0;
    while (mig_sys_rst_n !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== HOLD) begin
      errors++;
      $display("FAIL nominal_mig_rise: got %0d cycles expected %0d", n, HOLD);
    end
    repeat (5) begin
      step();
      checks++;
      if (dut_vec !== {3'd3, 3'b100}) begin
        errors++;
        $display("FAIL nominal_wait_calib: got %b expected %b", dut_vec, {3'd3, 3'b100});
      end
    end
    calib_complete = 1'b1;
    step();
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL nominal_settle_entry: got %0d expected 4", state_o);
    end
    n = 0;
    while (user_reset_n !== 1'b1 && n < 20) begin
      step();
      n++;
      checks++;
      if (timeout_error !== 1'b0) begin
        errors++;
        $display("FAIL nominal_no_timeout: got %b expected 0", timeout_error);
      end
    end
    checks++;
    if (n !== SET) begin
      errors++;
      $display("FAIL nominal_user_rise: got %0d cycles expected %0d", n, SET);
    end
    repeat (3) step();
    checks++;
    if (dut_vec !== {3'd5, 3'b110}) begin
      errors++;
      $display("FAIL nominal_run_hold: got %b expected %b", dut_vec, {3'd5, 3'b110});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    int n;
    start_from_reset(1'b1, 1'b0);
    n = 0;
    while (state_o !== 3'd3 && n < 30) begin
      step();
      n++;
    end
    n = 0;
    while (timeout_error !== 1'b1 && n < 40) begin
      step();
      n++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL timeout_track: got %b expected %b", dut_vec, model_vec());
      end
    end
    checks++;
    if (n !== TMO) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TMO);
    end
    checks++;
    if (dut_vec !== {3'd6, 3'b001}) begin
      errors++;
      $display("FAIL timeout_outputs: got %b expected %b", dut_vec, {3'd6, 3'b001});
    end
    calib_complete = 1'b1;
    repeat (6) step();
    checks++;
    if (dut_vec !== {3'd6, 3'b001}) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected %b", dut_vec, {3'd6, 3'b001});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reset asserted mid-cycle while the sequencer sits in ERROR.
  task automatic test_reset_in_error();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 6'b000_000) begin
      errors++;
      $display("FAIL error_async_reset: got %b expected %b", dut_vec, 6'b000_000);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (dut_vec !== {3'd1, 3'b000}) begin
      errors++;
      $display("FAIL error_reset_restart: got %b expected %b", dut_vec, {3'd1, 3'b000});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lock_loss_run();
    int n;
    start_from_reset(1'b1, 1'b1);
    n = 0;
    while (user_reset_n !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (state_o !== 3'd5) begin
      errors++;
      $display("FAIL lockloss_reach_run: got %0d expected 5", state_o);
    end
    pll_locked = 1'b0;
    n = 0;
    while (user_reset_n !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL lockloss_latency: got %0d cycles expected 3", n);
    end
    checks++;
    if (dut_vec !== {3'd1, 3'b000}) begin
      errors++;
      $display("FAIL lockloss_outputs: got %b expected %b", dut_vec, {3'd1, 3'b000});
    end
    repeat (10 - n) step();
    pll_locked = 1'b1;
    n = 0;
    while (state_o !== 3'd2 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL relock_hold_entry: got %0d cycles expected 3", n);
    end
    n = 0;
    while (mig_sys_rst_n !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== HOLD) begin
      errors++;
      $display("FAIL relock_mig_rise: got %0d cycles expected %0d", n, HOLD);
    end
    // calib_complete is already high: one cycle in WAIT_CALIB, then SETTLE.
    n = 0;
    while (user_reset_n !== 1'b1 && n < 20) begin
      step();
      n++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL relock_track: got %b expected %b", dut_vec, model_vec());
      end
    end
    checks++;
    if (n !== SET + 1) begin
      errors++;
      $display("FAIL relock_user_rise: got %0d cycles expected %0d", n, SET + 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_calib_glitch();
    int n;
    start_from_reset(1'b1, 1'b0);
    n = 0;
    while (state_o !== 3'd3 && n < 30) begin
      step();
      n++;
    end
    calib_complete = 1'b1;
    step();
    step();
    checks++;
    if (dut_vec !== {3'd4, 3'b100}) begin
      errors++;
      $display("FAIL glitch_in_settle: got %b expected %b", dut_vec, {3'd4, 3'b100});
    end
    calib_complete = 1'b0;
    step();
    checks++;
    if (dut_vec !== {3'd3, 3'b100}) begin
      errors++;
      $display("FAIL glitch_back_to_calib: got %b expected %b", dut_vec, {3'd3, 3'b100});
    end
    calib_complete = 1'b1;
    step();
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL glitch_settle_reentry: got %0d expected 4", state_o);
    end
    n = 0;
    while (user_reset_n !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== SET) begin
      errors++;
      $display("FAIL glitch_full_settle: got %0d cycles expected %0d", n, SET);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Lock loss seen by the FSM on the very edge where the timeout would fire.
  task automatic test_simultaneous();
    int n;
    start_from_reset(1'b1, 1'b0);
    n = 0;
    while (state_o !== 3'd3 && n < 30) begin
      step();
      n++;
    end
    repeat (TMO - 3) step();
    pll_locked = 1'b0;
    step();
    step();
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL simul_pre_edge: got %0d expected 3", state_o);
    end
    step();
    checks++;
    if (dut_vec !== {3'd1, 3'b000}) begin
      errors++;
      $display("FAIL simul_lock_wins: got %b expected %b", dut_vec, {3'd1, 3'b000});
    end
    repeat (5) begin
      step();
      checks++;
      if (timeout_error !== 1'b0 || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL simul_no_error: got %b expected %b", dut_vec, model_vec());
      end
    end
    pll_locked = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    int reset_left;
    reset_left = 0;
    start_from_reset(1'b1, 1'b1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(39, 0) == 0) pll_locked = ~pll_locked;
      if ($urandom_range(7, 0) == 0)  calib_complete = ~calib_complete;
      if (reset_left > 0) begin
        reset_left--;
        if (reset_left == 0) reset_n = 1'b1;
      end
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b expected %b", cyc, dut_vec, model_vec());
      end
      if (reset_left == 0 && $urandom_range(149, 0) == 0) begin
        #2;
        reset_n = 1'b0;
        model_reset();
        reset_left = $urandom_range(3, 1);
        #1;
        checks++;
        if (dut_vec !== 6'b000_000) begin
          errors++;
          $display("FAIL random_async_reset: got %b expected %b", dut_vec, 6'b000_000);
        end
      end
    end
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_timeout();
    test_reset_in_error();
    test_lock_loss_run();
    test_calib_glitch();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr3_reset_sequencer.md
DDR3_RESET_SEQUENCER -- requirements
Module: ddr3_reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles the memory-controller reset stays asserted after PLL lock; legal range 1..65535.
REQ-002 Parameter CALIB_TIMEOUT_CYCLES, default 1000000: maximum cycles allowed for calibration in WAIT_CALIB; legal range 1..2^24-1.
REQ-003 Parameter SETTLE_CYCLES, default 8: cycles after calibration completes before user logic is released; legal range 1..65535.
REQ-004 clk  input  1  system clock; all state is clocked on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset, driven by the upstream synchronized reset (assertion asynchronous, deassertion synchronous to clk).
REQ-006 pll_locked  input  1  PLL lock, asynchronous to clk.
REQ-007 calib_complete  input  1  DDR3 controller calibration done, synchronous to clk.
REQ-008 mig_sys_rst_n  output  1  active-low reset to the DDR3 memory controller.
REQ-009 user_reset_n  output  1  active-low reset to user logic behind the controller.
REQ-010 timeout_error  output  1  calibration timeout flag, sticky until reset_n is asserted.
REQ-011 state_o  output  3  current state encoding, for debug.

Function
REQ-012 pll_locked SHALL pass through an internal two-flop synchronizer (ASYNC_REG); "locked" below is its output, 2 cycles of latency.
REQ-013 States and encodings: IDLE=0, WAIT_LOCK=1, HOLD=2, WAIT_CALIB=3, SETTLE=4, RUN=5, ERROR=6; encoding 7 is unreachable and SHALL recover to IDLE.
REQ-014 IDLE SHALL last exactly 1 cycle, then go to WAIT_LOCK.
REQ-015 WAIT_LOCK: when locked=1, go to HOLD; the counter is cleared on entry.
REQ-016 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to WAIT_CALIB with the counter cleared.
REQ-017 WAIT_CALIB: when calib_complete=1, go to SETTLE with the counter cleared.
REQ-018 WAIT_CALIB timeout: if the state has lasted CALIB_TIMEOUT_CYCLES cycles with calib_complete=0, go to ERROR.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to RUN.
REQ-020 SETTLE exit on calibration loss: if calib_complete=0 in any SETTLE cycle, go to WAIT_CALIB with the counter cleared.
REQ-021 RUN SHALL be held until a loss event occurs.
REQ-022 ERROR SHALL be held until reset_n is asserted; it is terminal.
REQ-023 Lock loss SHALL have the highest priority: locked=0 in HOLD, WAIT_CALIB, SETTLE or RUN goes to WAIT_LOCK next cycle, overriding every other transition (including a simultaneous timeout or calib_complete).
REQ-024 Calibration loss in RUN: calib_complete=0 while locked=1 SHALL go to WAIT_CALIB with mig_sys_rst_n held 1.
REQ-025 All outputs SHALL be registered, glitch-free, and reflect the state entered on the same clock edge.
REQ-026 mig_sys_rst_n SHALL be 1 in WAIT_CALIB, SETTLE and RUN, and 0 in every other state.
REQ-027 user_reset_n SHALL be 1 only in RUN.
REQ-028 timeout_error SHALL be 1 only in ERROR.
REQ-029 The counter SHALL be wide enough for the largest parameter and SHALL saturate, never wrap.

Reset
REQ-030 While reset_n=0: state=IDLE, counter=0, synchronizer flops=0, mig_sys_rst_n=0, user_reset_n=0, timeout_error=0, state_o=0.
REQ-031 reset_n assertion mid-operation (any state, including ERROR) SHALL take effect asynchronously and return all outputs to their reset values.

Verification (HOLD=4, TIMEOUT=16, SETTLE=3)
REQ-032 Nominal bring-up:
- stimulus: pll_locked=1 before reset release; calib_complete rises 5 cycles after mig_sys_rst_n rises.
- response: mig_sys_rst_n rises 4 cycles after HOLD entry; user_reset_n rises exactly 3 cycles after calib_complete is sampled high; timeout_error stays 0.
REQ-033 Calibration timeout:
- stimulus: calib_complete held 0.
- response: timeout_error=1 exactly 16 cycles after WAIT_CALIB entry; mig_sys_rst_n=0; user_reset_n=0.
- then: calib_complete rising later SHALL have no effect.
REQ-034 Lock loss in RUN:
- stimulus: drop pll_locked for 10 cycles.
- response: user_reset_n and mig_sys_rst_n fall 3 cycles after the drop (2 sync + 1 registered); the full sequence replays after relock.
REQ-035 Calibration glitch:
- stimulus: calib_complete=0 for 1 cycle in SETTLE.
- response: return to WAIT_CALIB; SETTLE restarts with a full 3 cycles; user_reset_n never pulses high.
REQ-036 Simultaneous events:
- stimulus: lock loss in the same cycle as the WAIT_CALIB timeout.
- response: WAIT_LOCK entered; timeout_error stays 0.
REQ-037 Reset in ERROR: assert reset_n -> all outputs 0 immediately; state_o=0.
